// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: state encoding and default sizes shared by the MNIST job sequencer.
package nn_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_X,
      S_COMPUTE,
      S_DONE,
      S_ERR
   } nn_ctrl_state_t;
   localparam int NN_W_ADDR_LEN      = 20;
   localparam int NN_X_ADDR_LEN      = 10;
   localparam int NN_W_SEL_LEN       = 2;
   localparam int NN_X_SEL_LEN       = 2;
   localparam int NN_W_LOAD_CNT      = 100352;
   localparam int NN_X_LOAD_CNT      = 784;
   localparam int NN_TIMEOUT_CYCLES  = 2000000;
endpackage

// File: rtl/ld_addr_cnt.sv
// ld_addr_cnt: clearable load-address counter that parks at LIMIT-1 and flags it.
module ld_addr_cnt #(
   parameter int W     = 10,
   parameter int LIMIT = 784
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   assign tc = cnt == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/nn_seq_ctrl.sv
// nn_seq_ctrl: loads weights/image bit-serially, hands memories to compute, reports done.
// Define NN_CTRL_TIMEOUT_EN to add the compute watchdog and the ERR state.
module nn_seq_ctrl
   import nn_ctrl_pkg::*;
#(
   parameter int W_ADDR_LEN     = NN_W_ADDR_LEN,
   parameter int X_ADDR_LEN     = NN_X_ADDR_LEN,
   parameter int W_SEL_LEN      = NN_W_SEL_LEN,
   parameter int X_SEL_LEN      = NN_X_SEL_LEN,
   parameter int W_LOAD_CNT     = NN_W_LOAD_CNT,
   parameter int X_LOAD_CNT     = NN_X_LOAD_CNT,
   parameter int TIMEOUT_CYCLES = NN_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  skip_w_load,
   input  logic [W_SEL_LEN-1:0]  w_bank,
   input  logic [X_SEL_LEN-1:0]  x_bank,
   input  logic                  ld_valid,
   input  logic                  ld_bit,
   output logic                  ld_ready,
   input  logic                  compute_finish,
   output logic                  load_compute_ctrl,
   output logic                  en_compute,
   output logic                  w_wq,
   output logic                  x_wq,
   output logic [W_ADDR_LEN-1:0] w_addr,
   output logic [X_ADDR_LEN-1:0] x_addr,
   output logic [W_SEL_LEN-1:0]  w_sel,
   output logic [X_SEL_LEN-1:0]  x_sel,
   output logic                  wx_write,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   nn_ctrl_state_t state, next_state;
   logic [W_SEL_LEN-1:0]  w_bank_q;
   logic [X_SEL_LEN-1:0]  x_bank_q;
   logic [W_ADDR_LEN-1:0] w_cnt;
   logic [X_ADDR_LEN-1:0] x_cnt;
   logic w_tc, x_tc, start_acc, w_xfer, x_xfer, expire, loading_n, stay_compute;
   assign start_acc = start && (state == S_IDLE || state == S_ERR);
   assign w_xfer    = state == S_LOAD_W && ld_valid && ld_ready;
   assign x_xfer    = state == S_LOAD_X && ld_valid && ld_ready;
   ld_addr_cnt #(.W(W_ADDR_LEN), .LIMIT(W_LOAD_CNT)) u_w_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(w_xfer), .cnt(w_cnt), .tc(w_tc)
   );
   ld_addr_cnt #(.W(X_ADDR_LEN), .LIMIT(X_LOAD_CNT)) u_x_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(x_xfer), .cnt(x_cnt), .tc(x_tc)
   );
`ifdef NN_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] t_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) t_cnt <= '0;
      else t_cnt <= state == S_COMPUTE ? t_cnt + 1'b1 : '0;
   assign expire = state == S_COMPUTE && t_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_ERR: if (start) next_state = skip_w_load ? S_LOAD_X : S_LOAD_W;
         S_LOAD_W:      if (w_xfer && w_tc) next_state = S_LOAD_X;
         S_LOAD_X:      if (x_xfer && x_tc) next_state = S_COMPUTE;
         S_COMPUTE:     next_state = compute_finish ? S_DONE : expire ? S_ERR : S_COMPUTE;
         default:       next_state = S_IDLE;
      endcase
      loading_n    = next_state == S_LOAD_W || next_state == S_LOAD_X;
      // ownership flips one cycle into COMPUTE so the last x write is never overlapped
      stay_compute = state == S_COMPUTE && next_state == S_COMPUTE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         ld_ready          <= 1'b0;
         load_compute_ctrl <= 1'b1;
         en_compute        <= 1'b0;
         w_wq              <= 1'b0;
         x_wq              <= 1'b0;
         w_addr            <= '0;
         x_addr            <= '0;
         w_sel             <= '0;
         x_sel             <= '0;
         wx_write          <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
         w_bank_q          <= '0;
         x_bank_q          <= '0;
      end else begin
         state             <= next_state;
         ld_ready          <= loading_n;
         load_compute_ctrl <= !stay_compute;
         en_compute        <= stay_compute;
         busy              <= loading_n || next_state == S_COMPUTE;
         done              <= next_state == S_DONE;
         err               <= next_state == S_ERR;
         w_wq              <= w_xfer;
         x_wq              <= x_xfer;
         if (start_acc) begin
            w_bank_q <= w_bank;
            x_bank_q <= x_bank;
         end
         if (w_xfer) begin
            w_addr <= w_cnt;
            w_sel  <= w_bank_q;
         end
         if (x_xfer) begin
            x_addr <= x_cnt;
            x_sel  <= x_bank_q;
         end
         if (w_xfer || x_xfer) wx_write <= ld_bit;
      end
   end
endmodule

// File: doc/nn_seq_ctrl.md
# nn_seq_ctrl

Job sequencer for the MNIST inference top. It owns the `load_compute_ctrl` select and `en_compute` enable that sit in front of the weight/activation memory system. Per job it does three things in order: streams weights and then the input image bit-serially from an off-chip loader into `mem_sys` through a valid/ready handshake, hands the memories to the compute module, and reports completion. It replaces direct off-chip driving of the memory-port mux with a counted, address-generating state machine.

## Interface
Parameters:
- `W_ADDR_LEN`, 20: weight memory address width.
- `X_ADDR_LEN`, 10: activation memory address width.
- `W_SEL_LEN`, 2: weight bank-select width.
- `X_SEL_LEN`, 2: activation bank-select width.
- `W_LOAD_CNT`, 100352: weight bits per load. Legal range 1..2^W_ADDR_LEN.
- `X_LOAD_CNT`, 784: image bits per load. Legal range 1..2^X_ADDR_LEN.
- `TIMEOUT_CYCLES`, 2000000: compute watchdog limit. Used only with `NN_CTRL_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  job request; sampled in IDLE and ERR only.
- `skip_w_load`  in  1  sampled with `start`; 1 = reuse resident weights, go straight to LOAD_X.
- `w_bank`  in  W_SEL_LEN  weight bank for this load; sampled with `start`.
- `x_bank`  in  X_SEL_LEN  activation bank for this load; sampled with `start`.
- `ld_valid`  in  1  loader has a bit.
- `ld_bit`  in  1  loader data bit.
- `ld_ready`  out  1  controller accepts a bit this cycle.
- `compute_finish`  in  1  from compute module.
- `load_compute_ctrl`  out  1  1 = memory ports driven by this block; 0 = compute module owns them.
- `en_compute`  out  1  compute module enable.
- `w_wq`, `x_wq`  out  1  active-high write enables.
- `w_addr`  out  W_ADDR_LEN  weight write address.
- `x_addr`  out  X_ADDR_LEN  activation write address.
- `w_sel`  out  W_SEL_LEN  weight bank select.
- `x_sel`  out  X_SEL_LEN  activation bank select.
- `wx_write`  out  1  shared write data bit.
- `busy`  out  1  high in LOAD_W, LOAD_X, COMPUTE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  watchdog expired; sticky until next accepted `start`.

## Operation
- States: IDLE, LOAD_W, LOAD_X, COMPUTE, DONE, ERR.
- IDLE/ERR + `start`:
  - latch `w_bank` and `x_bank`, clear both counters, clear `err`.
  - go to LOAD_X if `skip_w_load`, else LOAD_W.
- LOAD_W:
  - `ld_ready`=1. A transfer is `ld_valid && ld_ready`.
  - On a transfer, the next cycle has `w_wq`=1, `w_addr`=count, `wx_write`=`ld_bit`, and the count increments.
  - The transfer at count `W_LOAD_CNT-1` moves the FSM to LOAD_X.
- LOAD_X: same rule on the x port. The transfer at `X_LOAD_CNT-1` moves the FSM to COMPUTE.
- COMPUTE:
  - `load_compute_ctrl`=0, `en_compute`=1, `ld_ready`=0.
  - `compute_finish`=1 moves the FSM to DONE.
- DONE: `done`=1 for one cycle, `en_compute`=0, then IDLE. This guarantees `en_compute` is low for at least 2 cycles between jobs.
- `start` outside IDLE/ERR is ignored. `compute_finish` outside COMPUTE is ignored.
- Counters stop at their terminal count, so no wrap is possible. Terminal compare is on the pre-increment value.
- Address/sel/data outputs hold their last values when no write is issued. Only the `*_wq` signals pulse.

## Timing
- Reset values: all outputs 0 except `load_compute_ctrl`=1. State=IDLE, counters=0. Reset clears `*_wq` immediately, so no partial write survives.
- All outputs are registered.
- Write latency: 1 cycle from transfer to `*_wq` assertion.
- Throughput: 1 bit/cycle with `ld_valid` held high. A full default job loads in `W_LOAD_CNT+X_LOAD_CNT` cycles, plus 1 cycle for the COMPUTE entry.
- `ld_ready` drops in the cycle after the final x transfer. The loader must not count on a transfer in that cycle.
- `load_compute_ctrl` falls and `en_compute` rises on the same edge. This is the cycle after the last `x_wq` pulse, so there is no port-ownership overlap.
- `done` rises 1 cycle after `compute_finish` is sampled high.

## Configuration
- `NN_CTRL_TIMEOUT_EN` defined:
  - a cycle counter runs in COMPUTE.
  - reaching `TIMEOUT_CYCLES` without `compute_finish` goes to ERR: `en_compute`=0, `load_compute_ctrl`=1, `err`=1.
  - `compute_finish` on the same cycle as expiry wins, and the FSM goes to DONE.
- Undefined: no counter, COMPUTE waits indefinitely, `err` is tied to 0, and ERR is unreachable.

## Structure
- Package `nn_ctrl_pkg` holds:
  - the state encoding typedef (`nn_ctrl_state_t`);
  - default load-count and timeout localparams;
  - the bank/address width defaults shared with the top.
- One sub-module, `ld_addr_cnt`: a clearable, enable-incrementing counter with a terminal-count flag, parameterised by width and limit. It is instantiated twice (weights, activations).

## Test plan
Bench overrides: W_LOAD_CNT=8, X_LOAD_CNT=4, TIMEOUT_CYCLES=20.
- Reset mid-LOAD_W (after 3 transfers) -> next cycle IDLE, `load_compute_ctrl`=1, all `*_wq`=0. Next `start` writes from `w_addr`=0.
- `start` with `skip_w_load`=0 and `ld_valid` held high, `ld_bit` pattern 10110011 then 0101 -> writes as follows, then `en_compute`=1 on cycle 14 after `start`:
  - `w_addr` 0..7 with those bits on `w_sel`=`w_bank`;
  - `x_addr` 0..3 with 0,1,0,1.
- `ld_valid` toggling every other cycle -> exactly one write per accepted bit, no address skips, final address 7/3.
- `compute_finish` pulsed at COMPUTE+5 -> `done` one cycle later, `busy` low, a second `compute_finish` in IDLE is ignored.
- `skip_w_load`=1 -> zero `w_wq` pulses, 4 `x_wq` pulses, COMPUTE entered.
- With `NN_CTRL_TIMEOUT_EN`, `compute_finish` never asserted -> `err`=1 after 20 COMPUTE cycles and `en_compute`=0. The next `start` clears `err`.
